// File: rtl/rom_defs_pkg.sv
// ----------------------------------------------------------------------------
// rom_defs : shared definitions for the ROM fetch sequencer.
//   - default ROM address and data widths
//   - FSM state encoding (IDLE=0, FETCH=1, VALID=2)
//   - small arithmetic helper used by the sequencer
// No ports (package).
// ----------------------------------------------------------------------------
package rom_defs;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_e;

    // Modular add of one byte into a running byte-wide sum.
    function automatic logic [7:0] sum_add8(input logic [7:0] acc, input logic [7:0] val);
        return acc + val;
    endfunction

endpackage

// File: rtl/rom_fetch_unit.sv
// ----------------------------------------------------------------------------
// rom_fetch_unit : address sequencer in front of a combinational ROM.
//   Walks rom_address from start_addr to end_addr (inclusive, wrapping through
//   2^ADDR_W-1 -> 0 when start_addr > end_addr), captures each ROM byte into
//   out_data and hands it downstream over a valid/ready handshake.
//
// Optional feature macro: ROM_FETCH_CHECKSUM_EN
//   When defined, a checksum output accumulates every accepted byte
//   (mod 2^DATA_W); it clears when a start is accepted and holds after done.
//
// Ports:
//   clk          in   1       rising-edge clock
//   rst_n        in   1       asynchronous active-low reset
//   start        in   1       one-cycle request, honoured only in IDLE
//   start_addr   in   ADDR_W  first address (sampled with start)
//   end_addr     in   ADDR_W  last address, inclusive (sampled with start)
//   rom_address  out  ADDR_W  registered ROM address
//   rom_data     in   DATA_W  ROM data, combinational from rom_address
//   out_data     out  DATA_W  captured byte
//   out_valid    out  1       out_data holds an unconsumed byte
//   out_ready    in   1       consumer accepts when out_valid & out_ready
//   busy         out  1       sequencer not in IDLE
//   done         out  1       one-cycle pulse after the last byte is accepted
//   checksum     out  DATA_W  (ROM_FETCH_CHECKSUM_EN only) running byte sum
// ----------------------------------------------------------------------------
module rom_fetch_unit
    import rom_defs::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
`ifdef ROM_FETCH_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    fetch_state_e      state_r;
    fetch_state_e      next_state_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic [ADDR_W-1:0] last_r;
    logic [ADDR_W-1:0] last_nxt_s;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] data_nxt_s;
    logic              valid_r;
    logic              valid_nxt_s;
    logic              done_r;
    logic              done_nxt_s;
    logic              busy_r;
    logic              handshake_s;

    assign handshake_s = valid_r & out_ready;

    // Next-state and next-register-value decode for the fetch FSM.
    always_comb begin
        next_state_s = state_r;
        addr_nxt_s   = addr_r;
        last_nxt_s   = last_r;
        data_nxt_s   = data_r;
        valid_nxt_s  = valid_r;
        done_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    addr_nxt_s   = start_addr;
                    last_nxt_s   = end_addr;
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // rom_address was registered last edge, so rom_data has settled.
                data_nxt_s   = rom_data;
                valid_nxt_s  = 1'b1;
                next_state_s = ST_VALID;
            end
            ST_VALID: begin
                if (handshake_s) begin
                    valid_nxt_s = 1'b0;
                    if (addr_r == last_r) begin
                        done_nxt_s   = 1'b1;
                        next_state_s = ST_IDLE;
                    end else begin
                        // Natural wrap of the ADDR_W-bit add gives the 2^ADDR_W-1 -> 0 step.
                        addr_nxt_s   = addr_r + ADDR_W'(1);
                        next_state_s = ST_FETCH;
                    end
                end else begin
                    next_state_s = ST_VALID;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean idle.
                valid_nxt_s  = 1'b0;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            addr_r  <= '0;
            last_r  <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            addr_r  <= addr_nxt_s;
            last_r  <= last_nxt_s;
            data_r  <= data_nxt_s;
            valid_r <= valid_nxt_s;
            done_r  <= done_nxt_s;
            // busy is registered from the next state so it equals (state != IDLE).
            busy_r  <= (next_state_s != ST_IDLE);
        end
    end

    assign rom_address = addr_r;
    assign out_data    = data_r;
    assign out_valid   = valid_r;
    assign busy        = busy_r;
    assign done        = done_r;

`ifdef ROM_FETCH_CHECKSUM_EN
    logic [DATA_W-1:0] csum_r;

    // Running sum of accepted bytes; cleared when a new start is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_r <= '0;
        end else if ((state_r == ST_IDLE) && start) begin
            csum_r <= '0;
        end else if ((state_r == ST_VALID) && handshake_s) begin
            csum_r <= csum_r + data_r;
        end else begin
            csum_r <= csum_r;
        end
    end

    assign checksum = csum_r;
`endif

endmodule

// File: tb/tb_rom_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_rom_fetch_unit : self-checking bench for rom_fetch_unit with a
// combinational ROM model mem[a] = a ^ 8'hA5. A table of per-byte records
// drives whole transfers; hand-written sequences cover reset mid-transfer and
// a start taken in the done cycle.
// ----------------------------------------------------------------------------
module tb_rom_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] start_addr;
    logic [7:0] end_addr;
    logic [7:0] rom_address;
    logic [7:0] rom_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
`ifdef ROM_FETCH_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    rom_fetch_unit #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .rom_address(rom_address),
        .rom_data   (rom_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
`ifdef ROM_FETCH_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    // ROM model
    assign rom_data = rom_address ^ 8'hA5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       first;
        logic [7:0] sa;
        logic [7:0] ea;
        logic [7:0] addr;
        logic [7:0] data;
        logic       last;
        int         stall;
        logic       poke;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic f, input logic [7:0] sa, input logic [7:0] ea,
                                input logic [7:0] a, input logic [7:0] d, input logic l,
                                input int st, input logic pk);
        vec_t v;
        v.first = f; v.sa = sa; v.ea = ea; v.addr = a; v.data = d;
        v.last = l; v.stall = st; v.poke = pk;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Hand-computed expectations: data = addr ^ A5.
        tbl[0]  = mk(1'b1, 8'h09, 8'h09, 8'h09, 8'hAC, 1'b1, 0, 1'b0);
        tbl[1]  = mk(1'b1, 8'h01, 8'h07, 8'h01, 8'hA4, 1'b0, 0, 1'b0);
        tbl[2]  = mk(1'b0, 8'h01, 8'h07, 8'h02, 8'hA7, 1'b0, 0, 1'b0);
        tbl[3]  = mk(1'b0, 8'h01, 8'h07, 8'h03, 8'hA6, 1'b0, 0, 1'b0);
        tbl[4]  = mk(1'b0, 8'h01, 8'h07, 8'h04, 8'hA1, 1'b0, 0, 1'b0);
        tbl[5]  = mk(1'b0, 8'h01, 8'h07, 8'h05, 8'hA0, 1'b0, 0, 1'b0);
        tbl[6]  = mk(1'b0, 8'h01, 8'h07, 8'h06, 8'hA3, 1'b0, 0, 1'b0);
        tbl[7]  = mk(1'b0, 8'h01, 8'h07, 8'h07, 8'hA2, 1'b1, 0, 1'b0);
        tbl[8]  = mk(1'b1, 8'h03, 8'h05, 8'h03, 8'hA6, 1'b0, 5, 1'b0);
        tbl[9]  = mk(1'b0, 8'h03, 8'h05, 8'h04, 8'hA1, 1'b0, 0, 1'b0);
        tbl[10] = mk(1'b0, 8'h03, 8'h05, 8'h05, 8'hA0, 1'b1, 0, 1'b0);
        tbl[11] = mk(1'b1, 8'hFE, 8'h01, 8'hFE, 8'h5B, 1'b0, 0, 1'b0);
        tbl[12] = mk(1'b0, 8'hFE, 8'h01, 8'hFF, 8'h5A, 1'b0, 0, 1'b0);
        tbl[13] = mk(1'b0, 8'hFE, 8'h01, 8'h00, 8'hA5, 1'b0, 0, 1'b0);
        tbl[14] = mk(1'b0, 8'hFE, 8'h01, 8'h01, 8'hA4, 1'b1, 0, 1'b0);
        tbl[15] = mk(1'b1, 8'h01, 8'h03, 8'h01, 8'hA4, 1'b0, 0, 1'b1);
        tbl[16] = mk(1'b0, 8'h01, 8'h03, 8'h02, 8'hA7, 1'b0, 0, 1'b1);
        tbl[17] = mk(1'b0, 8'h01, 8'h03, 8'h03, 8'hA6, 1'b1, 0, 1'b1);

        rst_n = 1'b0; start = 1'b0; start_addr = 8'h00; end_addr = 8'h00; out_ready = 1'b0;
        step();
        step();
        check("rst_addr",  32'(rom_address), 32'h0);
        check("rst_data",  32'(out_data),    32'h0);
        check("rst_valid", 32'(out_valid),   32'h0);
        check("rst_busy",  32'(busy),        32'h0);
        check("rst_done",  32'(done),        32'h0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].first) begin
                start = 1'b1; start_addr = tbl[i].sa; end_addr = tbl[i].ea;
                step();
                start = 1'b0;
            end
            // FETCH cycle: out_ready held high here must not consume anything.
            out_ready = (tbl[i].stall == 0);
            if (tbl[i].poke) begin
                start = 1'b1; start_addr = 8'h40; end_addr = 8'h40;
            end
            check($sformatf("fetch_valid[%0d]", i), 32'(out_valid), 32'h0);
            check($sformatf("fetch_busy[%0d]", i),  32'(busy),      32'h1);
            step();
            start = 1'b0;
            check($sformatf("valid[%0d]", i), 32'(out_valid),   32'h1);
            check($sformatf("addr[%0d]", i),  32'(rom_address), 32'(tbl[i].addr));
            check($sformatf("data[%0d]", i),  32'(out_data),    32'(tbl[i].data));
            for (int k = 0; k < tbl[i].stall; k++) begin
                step();
                check($sformatf("stall_valid[%0d]", i), 32'(out_valid),   32'h1);
                check($sformatf("stall_addr[%0d]", i),  32'(rom_address), 32'(tbl[i].addr));
                check($sformatf("stall_data[%0d]", i),  32'(out_data),    32'(tbl[i].data));
            end
            out_ready = 1'b1;
            step();
            check($sformatf("hs_valid[%0d]", i), 32'(out_valid), 32'h0);
            check($sformatf("hs_done[%0d]", i),  32'(done),      32'(tbl[i].last));
            check($sformatf("hs_busy[%0d]", i),  32'(!tbl[i].last), 32'(busy));
            if (tbl[i].last) begin
                out_ready = 1'b0;
                step();
                check($sformatf("idle_done[%0d]", i), 32'(done), 32'h0);
                check($sformatf("idle_busy[%0d]", i), 32'(busy), 32'h0);
            end
        end

`ifdef ROM_FETCH_CHECKSUM_EN
        // A4 + A7 + A6 = 0x1F1 -> F1, held after done.
        check("checksum_1_3", 32'(checksum), 32'hF1);
        step();
        check("checksum_hold", 32'(checksum), 32'hF1);
`endif

        // Start accepted in the done cycle.
        start = 1'b1; start_addr = 8'h09; end_addr = 8'h09;
        step();
        start = 1'b0; out_ready = 1'b1;
        step();
        step();
        check("dc_done", 32'(done), 32'h1);
        start = 1'b1; start_addr = 8'h20; end_addr = 8'h20;
        step();
        start = 1'b0; out_ready = 1'b0;
        check("dc_busy",  32'(busy),      32'h1);
        check("dc_valid", 32'(out_valid), 32'h0);
        step();
        check("dc_addr", 32'(rom_address), 32'h20);
        check("dc_data", 32'(out_data),    32'h85);
`ifdef ROM_FETCH_CHECKSUM_EN
        check("dc_csum_clr", 32'(checksum), 32'h0);
`endif
        out_ready = 1'b1;
        step();
        check("dc_done2", 32'(done), 32'h1);
        out_ready = 1'b0;
        step();

        // Reset mid-transfer at address 4.
        start = 1'b1; start_addr = 8'h03; end_addr = 8'h06;
        step();
        start = 1'b0; out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        step();
        check("mr_addr4", 32'(rom_address), 32'h04);
        check("mr_valid", 32'(out_valid),   32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_rst_addr",  32'(rom_address), 32'h0);
        check("mr_rst_data",  32'(out_data),    32'h0);
        check("mr_rst_valid", 32'(out_valid),   32'h0);
        check("mr_rst_busy",  32'(busy),        32'h0);
        check("mr_rst_done",  32'(done),        32'h0);
`ifdef ROM_FETCH_CHECKSUM_EN
        check("mr_rst_csum",  32'(checksum),    32'h0);
`endif
        #2 rst_n = 1'b1;
        step();
        start = 1'b1; start_addr = 8'h05; end_addr = 8'h05;
        step();
        start = 1'b0;
        step();
        check("mr_new_addr", 32'(rom_address), 32'h05);
        check("mr_new_data", 32'(out_data),    32'hA0);
        out_ready = 1'b1;
        step();
        check("mr_new_done", 32'(done), 32'h1);
        out_ready = 1'b0;
        step();
        check("mr_new_busy", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
